// File: rtl/pwm_deadtime_if.sv
// Byte-wide register bus for pwm_deadtime (rd/wr strobes, 7-bit address).
// master: drives rd, wr, adrs, din; slave: returns registered dout.
interface pwm_deadtime_if;
    logic       rd;
    logic       wr;
    logic [6:0] adrs;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output rd, wr, adrs, din, input dout);
    modport slave (input rd, wr, adrs, din, output dout);
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate drive with break-before-make dead time and sticky fault.
// Ports: clk, rst (async active-low), bus (register slave), pwm_in (raw PWM),
// fault (driver fault), pwm_hi / pwm_lo (high-side / low-side gate drive).
module pwm_deadtime #(
    parameter int CHANNELS = 8,
    parameter int DT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    pwm_deadtime_if.slave       bus,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic                fault,
    output logic [CHANNELS-1:0] pwm_hi,
    output logic [CHANNELS-1:0] pwm_lo
);

    localparam logic [6:0] A_CH_EN  = 7'h00;
    localparam logic [6:0] A_DT     = 7'h04;
    localparam logic [6:0] A_STATUS = 7'h08;
    localparam logic [6:0] A_HI     = 7'h0C;
    localparam logic [6:0] A_LO     = 7'h10;

    localparam logic [DT_W-1:0] DT_RST = DT_W'(10);

    typedef enum logic [2:0] {
        S_OFF,
        S_HI_ON,
        S_DT_TO_LO,
        S_LO_ON,
        S_DT_TO_HI
    } state_e;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [DT_W-1:0]     cnt_q   [CHANNELS];
    logic [DT_W-1:0]     cnt_d   [CHANNELS];

    logic [CHANNELS-1:0] in_r_q;
    logic [CHANNELS-1:0] hi_q, hi_d;
    logic [CHANNELS-1:0] lo_q, lo_d;
    logic [CHANNELS-1:0] ch_en_q, ch_en_d;
    logic [DT_W-1:0]     dt_q, dt_d;
    logic [DT_W-1:0]     dt_load;
    logic                dt_zero;
    logic                flag_q, flag_d;
    logic                halt;
    logic [7:0]          dout_q, dout_d;
    logic [7:0]          rd_data;
    logic                wr_en, wr_dt, wr_st;

    // Register writes; fault has priority over a same-edge clear.
    always_comb begin
        wr_en   = bus.wr && (bus.adrs == A_CH_EN);
        wr_dt   = bus.wr && (bus.adrs == A_DT);
        wr_st   = bus.wr && (bus.adrs == A_STATUS);
        ch_en_d = wr_en ? bus.din[CHANNELS-1:0] : ch_en_q;
        dt_d    = wr_dt ? bus.din[DT_W-1:0] : dt_q;
        flag_d  = flag_q;
        if (wr_st && bus.din[0] && !fault) begin
            flag_d = 1'b0;
        end
        if (fault) begin
            flag_d = 1'b1;
        end
    end

    // Read mux sees register values from before any same-edge write.
    always_comb begin
        rd_data = '0;
        case (bus.adrs)
            A_CH_EN:  rd_data = 8'(ch_en_q);
            A_DT:     rd_data = 8'(dt_q);
            A_STATUS: rd_data = {7'd0, flag_q};
            A_HI:     rd_data = 8'(pwm_hi);
            A_LO:     rd_data = 8'(pwm_lo);
            default:  rd_data = '0;
        endcase
        dout_d = bus.rd ? rd_data : dout_q;
    end

    // Per-channel FSM. A zero dead time skips the dead states entirely.
    always_comb begin
        halt    = fault | flag_q;
        dt_zero = (dt_q == '0);
        dt_load = dt_q - DT_W'(1);
        hi_d    = '0;
        lo_d    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            if (halt || !ch_en_q[n]) begin
                state_d[n] = S_OFF;
            end else begin
                unique case (state_q[n])
                    S_OFF: begin
                        cnt_d[n] = dt_load;
                        if (in_r_q[n]) begin
                            state_d[n] = dt_zero ? S_HI_ON : S_DT_TO_HI;
                        end else begin
                            state_d[n] = dt_zero ? S_LO_ON : S_DT_TO_LO;
                        end
                    end
                    S_HI_ON: begin
                        if (!in_r_q[n]) begin
                            cnt_d[n]   = dt_load;
                            state_d[n] = dt_zero ? S_LO_ON : S_DT_TO_LO;
                        end
                    end
                    S_LO_ON: begin
                        if (in_r_q[n]) begin
                            cnt_d[n]   = dt_load;
                            state_d[n] = dt_zero ? S_HI_ON : S_DT_TO_HI;
                        end
                    end
                    S_DT_TO_LO: begin
                        // Returning to hi is safe: lo was never driven.
                        if (in_r_q[n]) begin
                            state_d[n] = S_HI_ON;
                        end else if (cnt_q[n] == '0) begin
                            state_d[n] = S_LO_ON;
                        end else begin
                            cnt_d[n] = cnt_q[n] - DT_W'(1);
                        end
                    end
                    S_DT_TO_HI: begin
                        if (!in_r_q[n]) begin
                            state_d[n] = S_LO_ON;
                        end else if (cnt_q[n] == '0) begin
                            state_d[n] = S_HI_ON;
                        end else begin
                            cnt_d[n] = cnt_q[n] - DT_W'(1);
                        end
                    end
                    default: state_d[n] = S_OFF;
                endcase
            end
            hi_d[n] = (state_d[n] == S_HI_ON);
            lo_d[n] = (state_d[n] == S_LO_ON);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                state_q[n] <= S_OFF;
                cnt_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_r_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ch_en_q <= '0;
            dt_q    <= DT_RST;
            flag_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            in_r_q  <= pwm_in;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ch_en_q <= ch_en_d;
            dt_q    <= dt_d;
            flag_q  <= flag_d;
            dout_q  <= dout_d;
        end
    end

    // A live fault kills the gates without waiting for a clock edge.
    assign pwm_hi   = hi_q & ~{CHANNELS{fault}};
    assign pwm_lo   = lo_q & ~{CHANNELS{fault}};
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Testbench for pwm_deadtime: directed scenarios plus a randomised run,
// checked against a deadline-based model of the gate-drive rules.
module tb_pwm_deadtime;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] pwm_in = '0;
    logic       fault  = 1'b0;
    logic [7:0] pwm_hi;
    logic [7:0] pwm_lo;
    logic [7:0] rv;

    pwm_deadtime_if bus ();

    pwm_deadtime #(
        .CHANNELS(8),
        .DT_W    (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .pwm_in(pwm_in),
        .fault (fault),
        .pwm_hi(pwm_hi),
        .pwm_lo(pwm_lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: each channel drives side drv (0 none, 1 hi, 2 lo). When the
    // wanted side changes, the gate goes dead and the new side may assert
    // once the absolute cycle count reaches the deadline fixed at that time.
    // hd is the side being waited for (0 = channel was off).
    int         cyc    = 0;
    logic [7:0] m_en   = '0;
    logic [7:0] m_dt   = 8'd10;
    logic [7:0] m_in   = '0;
    logic [7:0] m_dout = '0;
    logic       m_flag = 1'b0;
    int         drv[8] = '{default: 0};
    int         hd[8]  = '{default: 0};
    int         dl[8]  = '{default: 0};
    logic [7:0] m_hi_now, m_lo_now, m_rv;
    int         tgt;
    logic       run;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_en   = '0;
            m_dt   = 8'd10;
            m_in   = '0;
            m_dout = '0;
            m_flag = 1'b0;
            for (int n = 0; n < 8; n++) begin
                drv[n] = 0;
                hd[n]  = 0;
            end
        end else begin
            cyc++;
            for (int n = 0; n < 8; n++) begin
                m_hi_now[n] = (drv[n] == 1) && !fault;
                m_lo_now[n] = (drv[n] == 2) && !fault;
            end
            if (bus.rd) begin
                case (bus.adrs)
                    7'h00:   m_rv = m_en;
                    7'h04:   m_rv = m_dt;
                    7'h08:   m_rv = {7'd0, m_flag};
                    7'h0C:   m_rv = m_hi_now;
                    7'h10:   m_rv = m_lo_now;
                    default: m_rv = 8'h00;
                endcase
                m_dout = m_rv;
            end
            for (int n = 0; n < 8; n++) begin
                run = m_en[n] && !fault && !m_flag;
                tgt = m_in[n] ? 1 : 2;
                if (!run) begin
                    drv[n] = 0;
                    hd[n]  = 0;
                end else if (drv[n] != 0) begin
                    if (drv[n] != tgt) begin
                        if (m_dt == 0) begin
                            drv[n] = tgt;
                        end else begin
                            drv[n] = 0;
                            dl[n]  = cyc + int'(m_dt);
                        end
                        hd[n] = tgt;
                    end
                end else if (hd[n] == 0) begin
                    hd[n] = tgt;
                    if (m_dt == 0) drv[n] = tgt;
                    else dl[n] = cyc + int'(m_dt);
                end else if (hd[n] != tgt) begin
                    drv[n] = tgt;
                    hd[n]  = tgt;
                end else if (cyc >= dl[n]) begin
                    drv[n] = tgt;
                end
            end
            if (bus.wr) begin
                case (bus.adrs)
                    7'h00: m_en = bus.din;
                    7'h04: m_dt = bus.din;
                    7'h08: if (bus.din[0] && !fault) m_flag = 1'b0;
                    default: ;
                endcase
            end
            if (fault) m_flag = 1'b1;
            m_in = pwm_in;
        end
    end

    logic [7:0] eh, el;
    always @(negedge clk) begin
        for (int n = 0; n < 8; n++) begin
            eh[n] = (drv[n] == 1) && !fault;
            el[n] = (drv[n] == 2) && !fault;
        end
        cmp("pwm_hi", pwm_hi, eh);
        cmp("pwm_lo", pwm_lo, el);
        cmp("dout", bus.dout, m_dout);
        if (m_dt != 0) cmp("overlap", pwm_hi & pwm_lo, 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
        bus.wr   = 1'b1;
        bus.adrs = a;
        bus.din  = d;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [6:0] a, output logic [7:0] v);
        bus.rd   = 1'b1;
        bus.adrs = a;
        tick();
        bus.rd = 1'b0;
        v      = bus.dout;
    endtask

    logic [6:0] radr[7] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h14, 7'h7F};
    int r;

    initial begin
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        bus.adrs = '0;
        bus.din  = '0;
        #1 rst = 1'b0;
        #1;
        cmp("rst_hi", pwm_hi, 8'h00);
        cmp("rst_lo", pwm_lo, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        rd_reg(7'h04, rv); cmp("rst_dt", rv, 8'd10);
        rd_reg(7'h00, rv); cmp("rst_en", rv, 8'h00);
        rd_reg(7'h08, rv); cmp("rst_st", rv, 8'h00);

        // Enable with dead time 3
        wr_reg(7'h04, 8'd3);
        pwm_in = 8'h00;
        wr_reg(7'h00, 8'h01);
        cmp("en_lo0", pwm_lo[0], 1'b0);
        tick(); tick(); tick();
        cmp("en_lo3", pwm_lo[0], 1'b0);
        tick();
        cmp("en_lo4", pwm_lo[0], 1'b1);
        pwm_in[0] = 1'b1;
        tick();
        cmp("sw_lo_k", pwm_lo[0], 1'b1);
        tick();
        cmp("sw_lo_k1", pwm_lo[0], 1'b0);
        cmp("sw_hi_k1", pwm_hi[0], 1'b0);
        tick(); tick();
        cmp("sw_hi_k3", pwm_hi[0], 1'b0);
        tick();
        cmp("sw_hi_k4", pwm_hi[0], 1'b1);

        // Glitch abort with dead time 5
        wr_reg(7'h04, 8'd5);
        pwm_in[0] = 1'b0;
        tick();
        cmp("gl_hi_a", pwm_hi[0], 1'b1);
        tick();
        cmp("gl_hi_a1", pwm_hi[0], 1'b0);
        pwm_in[0] = 1'b1;
        tick();
        cmp("gl_hi_a2", pwm_hi[0], 1'b0);
        tick();
        cmp("gl_hi_a3", pwm_hi[0], 1'b1);
        cmp("gl_lo_a3", pwm_lo[0], 1'b0);

        // Zero dead time, all channels
        pwm_in = 8'hFF;
        wr_reg(7'h04, 8'd0);
        wr_reg(7'h00, 8'hFF);
        tick(); tick();
        cmp("dt0_hi", pwm_hi, 8'hFF);
        cmp("dt0_lo", pwm_lo, 8'h00);
        pwm_in = 8'h00;
        tick();
        cmp("dt0_hi_k", pwm_hi, 8'hFF);
        tick();
        cmp("dt0_hi_k1", pwm_hi, 8'h00);
        cmp("dt0_lo_k1", pwm_lo, 8'hFF);
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) pwm_in = ~pwm_in;
            tick();
        end
        pwm_in = 8'h00;
        tick(); tick(); tick(); tick();
        wr_reg(7'h04, 8'd1);
        pwm_in = 8'hFF;
        tick();
        cmp("dt1_lo_k", pwm_lo, 8'hFF);
        tick();
        cmp("dt1_hi_k1", pwm_hi, 8'h00);
        cmp("dt1_lo_k1", pwm_lo, 8'h00);
        tick();
        cmp("dt1_hi_k2", pwm_hi, 8'hFF);
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0) pwm_in = ~pwm_in;
            tick();
        end
        pwm_in = 8'hFF;
        tick(); tick(); tick();

        // Fault set, clear blocked, clear accepted
        fault = 1'b1;
        #1;
        cmp("flt_hi", pwm_hi, 8'h00);
        cmp("flt_lo", pwm_lo, 8'h00);
        tick();
        fault = 1'b0;
        #1;
        cmp("flt_hold", pwm_hi | pwm_lo, 8'h00);
        rd_reg(7'h08, rv); cmp("flt_st", rv, 8'h01);
        fault = 1'b1;
        wr_reg(7'h08, 8'h01);
        fault = 1'b0;
        rd_reg(7'h08, rv); cmp("clr_blk", rv, 8'h01);
        wr_reg(7'h08, 8'h01);
        rd_reg(7'h08, rv); cmp("clr_ok", rv, 8'h00);
        cmp("clr_dead", pwm_hi, 8'h00);
        tick();
        cmp("clr_resume", pwm_hi, 8'hFF);

        // Async reset during a dead interval
        wr_reg(7'h04, 8'd5);
        pwm_in = 8'h00;
        for (int i = 0; i < 8; i++) tick();
        pwm_in = 8'hFF;
        tick(); tick(); tick();
        #1 rst = 1'b0;
        #1;
        cmp("ar_hi", pwm_hi, 8'h00);
        cmp("ar_lo", pwm_lo, 8'h00);
        #1 rst = 1'b1;
        rd_reg(7'h00, rv); cmp("ar_en", rv, 8'h00);
        rd_reg(7'h04, rv); cmp("ar_dt", rv, 8'd10);
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) pwm_in = ~pwm_in;
            tick();
        end
        cmp("ar_quiet", pwm_hi | pwm_lo, 8'h00);

        // Randomised run
        wr_reg(7'h04, 8'd2);
        wr_reg(7'h00, 8'hA5);
        for (int i = 0; i < 1500; i++) begin
            bus.wr = 1'b0;
            bus.rd = 1'b0;
            fault  = 1'b0;
            if ($urandom_range(0, 3) == 0) pwm_in = 8'($urandom);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                bus.wr = 1'b1; bus.adrs = 7'h00; bus.din = 8'($urandom);
            end else if (r < 7) begin
                bus.wr = 1'b1; bus.adrs = 7'h04;
                bus.din = 8'($urandom_range(0, 6));
            end else if (r == 7) begin
                fault = 1'b1;
            end else if (r == 8) begin
                bus.wr = 1'b1; bus.adrs = 7'h08; bus.din = 8'h01;
            end else if (r == 9) begin
                bus.wr = 1'b1; bus.rd = 1'b1; bus.adrs = 7'h04;
                bus.din = 8'($urandom_range(1, 6));
            end else if (r < 25) begin
                bus.rd = 1'b1; bus.adrs = radr[$urandom_range(0, 6)];
            end
            tick();
        end
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        fault  = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the 8-channel PWM generator. Consumes its raw `pwmo[7:0]` and produces a complementary high-side/low-side gate-drive pair per channel, with programmable break-before-make dead time.
- Adds a sticky fault shutdown for the half-bridge drivers.
- Configured over the same byte-wide rd/wr/adrs/din/dout register bus as the PWM block.

Parameters:
- CHANNELS, 8, number of PWM channels/gate pairs
- DT_W, 8, width of dead-time counter/register (≤8, register is byte-wide)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- rd  input  1  register read strobe, sampled at clk edge
- wr  input  1  register write strobe, sampled at clk edge
- din  input  8  write data
- adrs  input  7  register address
- dout  output  8  registered read data
- pwm_in  input  CHANNELS  raw PWM from generator (clk-synchronous)
- fault  input  1  active-high driver fault, clk-synchronous
- pwm_hi  output  CHANNELS  high-side gate drive
- pwm_lo  output  CHANNELS  low-side gate drive

Behaviour:
- Reset (rst=0, async):
  - pwm_hi=0, pwm_lo=0, dout=0.
  - All channel FSMs go to OFF, in_r=0, fault flag=0.
  - CH_EN=0x00, DEAD_TIME=10.
- Register map:
  - 0x00 CH_EN (RW): bit n enables channel n.
  - 0x04 DEAD_TIME (RW): dead time in clk cycles.
  - 0x08 STATUS: bit0 sticky fault flag, RO except write-1-to-clear; bits7:1 read 0.
  - 0x0C HI_STATE (RO): current pwm_hi.
  - 0x10 LO_STATE (RO): current pwm_lo.
- Bus writes:
  - Take effect at the clk edge where wr=1.
  - Writes to RO or unmapped addresses are ignored.
- Bus reads:
  - rd=1 at an edge loads dout with the register value before any same-edge write.
  - Unmapped addresses return 0x00.
  - rd=0 holds dout.
- Input stage: pwm_in registered into in_r (1 cycle).
- Per-channel FSM, states OFF, HI_ON, DT_TO_LO, LO_ON, DT_TO_HI:
  - Outputs are registered decodes of the state:
    - HI_ON → hi=1, lo=0.
    - LO_ON → hi=0, lo=1.
    - All other states → both 0.
  - OFF: if enabled and not halted, go to DT_TO_HI if in_r=1, else DT_TO_LO. The counter is loaded, so a full dead time is always applied on enable.
  - HI_ON: in_r=0 → DT_TO_LO, counter loaded.
  - LO_ON: in_r=1 → DT_TO_HI, counter loaded.
  - DT_TO_LO:
    - in_r=1 → HI_ON (lo never asserted, so this is safe).
    - Otherwise, cnt==0 → LO_ON; else cnt decrements.
  - DT_TO_HI: symmetric to DT_TO_LO.
- Counter load:
  - Loads DEAD_TIME−1, so both outputs stay low for exactly DEAD_TIME cycles.
  - DEAD_TIME=0: HI_ON↔LO_ON switch directly on the same edge, with no dead time (documented hazard).
- Latency:
  - pwm_in edge sampled at edge k → in_r updates at edge k.
  - The active output drops at edge k+1.
  - The opposite output asserts at edge k+1+DEAD_TIME.
- A DEAD_TIME write during a dead interval affects only the next counter load.
- Disable (CH_EN bit cleared): the channel goes to OFF at the next edge, both outputs 0.
- Halt condition = fault=1 or fault flag=1:
  - fault=1 at any edge sets the flag at that edge.
  - Every FSM goes to OFF at that edge.
  - pwm_hi/pwm_lo are also combinationally forced to 0 while fault=1.
  - While the flag is set, all channels stay OFF regardless of CH_EN.
  - Writing 0x08 with bit0=1 clears the flag only if fault=0 on that edge; otherwise the flag stays set.
  - After the clear, enabled channels re-enter through a dead-time state.
- Invariant: pwm_hi[n] & pwm_lo[n] is never 1 in any cycle when DEAD_TIME≥1.

Test Plan:
- Reset values: release rst → pwm_hi=pwm_lo=0x00, read 0x04 → dout=10, read 0x00 → 0x00, read 0x08 → 0x00.
- Enable transition: write CH_EN=0x01, DEAD_TIME=3, hold pwm_in[0]=0 → lo[0] rises 3 cycles after OFF exit. Then pwm_in[0]=1 sampled at edge k → lo[0]=0 at k+1, hi[0]=1 at k+4.
- Glitch abort: channel 0 in HI_ON with DEAD_TIME=5, pulse pwm_in[0] low for 2 cycles → hi[0] drops, returns high, and lo[0] never asserts.
- DEAD_TIME=0: all 8 channels enabled, square wave on pwm_in → hi/lo swap on the same edge. Then set DEAD_TIME=1 → exactly one both-low cycle per edge.
- Fault path:
  - Fault set: channels running, fault=1 for 1 cycle → outputs 0 immediately and STATUS=0x01. Outputs stay 0 after fault drops.
  - Clear blocked: write 0x08=0x01 with fault=1 → STATUS stays 0x01.
  - Clear accepted: the same write with fault=0 → STATUS=0x00 and outputs resume after DEAD_TIME.
- Async reset mid-dead-time: assert rst between edges while in DT_TO_HI → all outputs 0 immediately, CH_EN=0x00. After release, no output asserts until re-enabled.
- Random regression: random pwm_in/CH_EN/DEAD_TIME writes → the assertion hi&lo==0 holds whenever DEAD_TIME≥1.
